// File: rtl/adpll_mon_pkg.sv
// rtl/adpll_mon_pkg.sv - shared FSM type and default sizing for the ADPLL frequency monitor
package adpll_mon_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    REPORT
  } mon_state_e;

  localparam int DEF_COUNT_WIDTH  = 12;
  localparam int DEF_GATE_CYCLES  = 2580;
  localparam int DEF_LOCK_WINDOWS = 4;
  localparam int TOL_WIDTH        = 4;

endpackage

// File: rtl/freq_mon_channel.sv
// rtl/freq_mon_channel.sv - per-clock edge counter, window result, tolerance check and lock streak
module freq_mon_channel
  import adpll_mon_pkg::*;
#(
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   gen_clk,
  input  logic                   run,
  input  logic                   report,
  input  logic [COUNT_WIDTH-1:0] target,
  input  logic [TOL_WIDTH-1:0]   tol,
  output logic [COUNT_WIDTH-1:0] result,
  output logic                   lock
);

  localparam int                     STREAK_W   = $clog2(LOCK_WINDOWS + 1);
  localparam logic [STREAK_W-1:0]    STREAK_MAX = STREAK_W'(LOCK_WINDOWS);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = '1;

  // [0],[1] are the synchroniser, [2] is the history bit for edge detection
  logic [2:0]                sync_q;
  logic                      edge_det;
  logic [COUNT_WIDTH-1:0]    cnt_q;
  logic [COUNT_WIDTH-1:0]    window_cnt;
  logic [STREAK_W-1:0]       streak_q;
  logic [STREAK_W-1:0]       streak_inc;
  logic signed [COUNT_WIDTH:0] diff;
  logic [COUNT_WIDTH:0]      abs_diff;
  logic                      in_tol;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], gen_clk};
    end
  end

  assign edge_det = sync_q[1] & ~sync_q[2];

  // Includes the edge seen in the REPORT cycle so the window spans all gate cycles
  assign window_cnt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + COUNT_WIDTH'(edge_det);

  assign diff     = $signed({1'b0, window_cnt}) - $signed({1'b0, target});
  assign abs_diff = diff[COUNT_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
  assign in_tol   = abs_diff <= (COUNT_WIDTH + 1)'(tol);

  assign streak_inc = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      result   <= '0;
      streak_q <= '0;
      lock     <= 1'b0;
    end else if (report) begin
      cnt_q  <= '0;
      result <= window_cnt;
      if (in_tol) begin
        streak_q <= streak_inc;
        lock     <= (streak_inc == STREAK_MAX);
      end else begin
        streak_q <= '0;
        lock     <= 1'b0;
      end
    end else if (run) begin
      cnt_q <= window_cnt;
    end else begin
      cnt_q    <= '0;
      streak_q <= '0;
      lock     <= 1'b0;
    end
  end

endmodule

// File: rtl/adpll_freq_monitor.sv
// rtl/adpll_freq_monitor.sv - gated frequency/lock monitor for NUM_CH ADPLL generated clocks
// Optional max-min spread output is built only when FREQ_MON_SPREAD_EN is defined.
module adpll_freq_monitor
  import adpll_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int SEL_WIDTH    = 2,
  parameter int COUNT_WIDTH  = DEF_COUNT_WIDTH,
  parameter int GATE_CYCLES  = DEF_GATE_CYCLES,
  parameter int LOCK_WINDOWS = DEF_LOCK_WINDOWS
) (
  input  logic                   fpga_clk_i,
  input  logic                   reset_i,
  input  logic                   enable_i,
  input  logic [NUM_CH-1:0]      clks_i,
  input  logic [COUNT_WIDTH-1:0] target_i,
  input  logic [TOL_WIDTH-1:0]   tol_i,
  input  logic [SEL_WIDTH-1:0]   sel_i,
  output logic [COUNT_WIDTH-1:0] count_o,
  output logic                   valid_o,
  output logic [NUM_CH-1:0]      lock_o,
  output logic                   all_lock_o
`ifdef FREQ_MON_SPREAD_EN
  ,
  output logic [COUNT_WIDTH-1:0] spread_o
`endif
);

  localparam int                 GATE_W   = $clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0]  LAST_RUN = GATE_W'(GATE_CYCLES - 2);

  mon_state_e             state;
  logic [GATE_W-1:0]      gate_cnt;
  logic                   run_st;
  logic                   report_st;
  logic [COUNT_WIDTH-1:0] result [NUM_CH];

  // RUN covers GATE_CYCLES-1 cycles and REPORT closes the window
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= IDLE;
      gate_cnt <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      unique case (state)
        IDLE: begin
          gate_cnt <= '0;
          if (enable_i) state <= RUN;
        end
        RUN: begin
          if (!enable_i) begin
            state    <= IDLE;
            gate_cnt <= '0;
          end else if (gate_cnt == LAST_RUN) begin
            state <= REPORT;
          end else begin
            gate_cnt <= gate_cnt + 1'b1;
          end
        end
        REPORT: begin
          valid_o  <= 1'b1;
          gate_cnt <= '0;
          state    <= enable_i ? RUN : IDLE;
        end
        default: begin
          state    <= IDLE;
          gate_cnt <= '0;
        end
      endcase
    end
  end

  assign run_st    = (state == RUN);
  assign report_st = (state == REPORT);

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    freq_mon_channel #(
      .COUNT_WIDTH  (COUNT_WIDTH),
      .LOCK_WINDOWS (LOCK_WINDOWS)
    ) u_ch (
      .clk     (fpga_clk_i),
      .rst     (reset_i),
      .gen_clk (clks_i[ch]),
      .run     (run_st),
      .report  (report_st),
      .target  (target_i),
      .tol     (tol_i),
      .result  (result[ch]),
      .lock    (lock_o[ch])
    );
  end

  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_o <= '0;
    end else if (int'(sel_i) < NUM_CH) begin
      count_o <= result[sel_i];
    end else begin
      count_o <= '0;
    end
  end

  assign all_lock_o = &lock_o;

`ifdef FREQ_MON_SPREAD_EN
  logic [COUNT_WIDTH-1:0] res_max;
  logic [COUNT_WIDTH-1:0] res_min;

  // Results only move on REPORT, so the spread follows valid_o without its own register
  always_comb begin
    res_max = result[0];
    res_min = result[0];
    for (int i = 1; i < NUM_CH; i++) begin
      if (result[i] > res_max) res_max = result[i];
      if (result[i] < res_min) res_min = result[i];
    end
  end

  assign spread_o = res_max - res_min;
`endif

endmodule
